uart_rx_fifo: RTL

Buffered UART receiver: synchronises the `rx` pin, deserialises 5–8 data-bit frames with optional parity and one or two stop bits, and pushes each received word with its error flags into an internal FIFO. It is the receive-side counterpart of the existing `fifo` + `uart_tx` transmit path. It sits behind the GPMC register bank: configuration comes from one register, and software drains the FIFO through `rd_en`. This replaces the unbuffered receive path, where a byte is lost if software misses `new_data`.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rx_fifo_fwft.sv | 71 +++++++
 rtl/uart_rx_fifo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver states, FIFO entry
// layout and timing limits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_t;

    localparam int ENTRY_DATA_LSB = 0;
    localparam int ENTRY_DATA_W   = 8;
    localparam int ENTRY_FE_BIT   = 8;
    localparam int ENTRY_PE_BIT   = 9;
    localparam int ENTRY_WIDTH    = 10;

    localparam int MIN_CLK_DIV    = 4;

endpackage

// File: rtl/rx_fifo_fwft.sv
// First-word-fall-through FIFO holding received words; owns the occupancy
// count, full/empty flags and the sticky overrun-drop rule.
module rx_fifo_fwft #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 10,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    input  logic                 overrun_clr,
    output logic [WIDTH-1:0]     rdata,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overrun
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_WIDTH'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered UART receiver: synchronises rx, deserialises 5-8 bit frames with
// optional parity and one or two stop bits, and queues words with error flags.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | timing to mid start bit; a high sample there is a glitch
// DATA   | sampling data bits, LSB first
// PARITY | sampling and checking the parity bit
// STOP1  | sampling first stop bit; pushes here for one-stop frames
// STOP2  | sampling second stop bit and pushing
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic [3:0]           bits_per_word,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop_bit,
    input  logic                 rd_en,
    output logic [7:0]           data_out,
    output logic                 frame_err_out,
    output logic                 parity_err_out,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    rx_state_t              state;
    rx_state_t              state_nxt;
    logic                   rx_meta;
    logic                   rxs;
    logic                   rxs_q;
    logic [1:0]             sync_vld;
    logic                   start_edge;
    logic [DIV_WIDTH-1:0]   eff_div;
    logic [3:0]             eff_bits;
    logic [DIV_WIDTH-1:0]   tmr;
    logic [DIV_WIDTH-1:0]   div_l;
    logic [3:0]             bits_l;
    logic                   par_en_l;
    logic                   par_odd_l;
    logic                   two_stop_l;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic                   frame_err;
    logic                   parity_err;
    logic                   sample;
    logic                   last_bit;
    logic                   push;
    logic [ENTRY_WIDTH-1:0] entry;
    logic [ENTRY_WIDTH-1:0] head;

    // rxs_q only tracks the line once reset values have flushed out of the
    // synchroniser, so a line held low through reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            sync_vld <= 2'b00;
            rxs_q    <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            sync_vld <= {sync_vld[0], 1'b1};
            rxs_q    <= rxs & sync_vld[1];
        end
    end

    assign start_edge = rxs_q & ~rxs;
    assign eff_div    = (clk_div < DIV_WIDTH'(MIN_CLK_DIV)) ? DIV_WIDTH'(MIN_CLK_DIV) : clk_div;
    assign eff_bits   = (bits_per_word >= 4'd5 && bits_per_word <= 4'd8) ? bits_per_word : 4'd8;
    assign sample     = (tmr == '0);
    assign last_bit   = ({1'b0, bit_idx} == bits_l - 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_edge) state_nxt = START;
            START:   if (sample) state_nxt = rxs ? IDLE : DATA;
            DATA:    if (sample && last_bit) state_nxt = par_en_l ? PARITY : STOP1;
            PARITY:  if (sample) state_nxt = STOP1;
            STOP1:   if (sample) state_nxt = two_stop_l ? STOP2 : IDLE;
            STOP2:   if (sample) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        push = 1'b0;
        case (state)
            STOP1:   push = sample & ~two_stop_l;
            STOP2:   push = sample;
            default: push = 1'b0;
        endcase
    end

    // The last stop sample is folded in combinationally since it pushes the same cycle.
    always_comb begin
        entry                                     = '0;
        entry[ENTRY_DATA_LSB +: ENTRY_DATA_W]     = shift;
        entry[ENTRY_FE_BIT]                       = frame_err | ~rxs;
        entry[ENTRY_PE_BIT]                       = parity_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr        <= '0;
            div_l      <= '0;
            bits_l     <= '0;
            par_en_l   <= 1'b0;
            par_odd_l  <= 1'b0;
            two_stop_l <= 1'b0;
            bit_idx    <= '0;
            shift      <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else if (state == IDLE) begin
            if (start_edge) begin
                tmr        <= (eff_div >> 1) - DIV_WIDTH'(1);
                div_l      <= eff_div;
                bits_l     <= eff_bits;
                par_en_l   <= parity_en;
                par_odd_l  <= parity_odd;
                two_stop_l <= two_stop_bit;
                bit_idx    <= '0;
                shift      <= '0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end
        end else if (sample) begin
            tmr <= div_l - DIV_WIDTH'(1);
            case (state)
                DATA: begin
                    shift[bit_idx] <= rxs;
                    bit_idx        <= bit_idx + 3'd1;
                end
                PARITY:  parity_err <= (^shift) ^ rxs ^ par_odd_l;
                STOP1:   if (!rxs) frame_err <= 1'b1;
                default: ;
            endcase
        end else begin
            tmr <= tmr - DIV_WIDTH'(1);
        end
    end

    rx_fifo_fwft #(
        .DEPTH     (FIFO_DEPTH),
        .WIDTH     (ENTRY_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .wdata       (entry),
        .pop         (rd_en),
        .overrun_clr (overrun_clr),
        .rdata       (head),
        .empty       (empty),
        .full        (full),
        .count       (counter),
        .overrun     (overrun)
    );

    assign data_out       = head[ENTRY_DATA_LSB +: ENTRY_DATA_W];
    assign frame_err_out  = head[ENTRY_FE_BIT];
    assign parity_err_out = head[ENTRY_PE_BIT];

endmodule
